// File: rtl/seg_pkg.sv
// Shared constants, hex glyph table and scan FSM state type for the seven-segment scanner.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic {StShow, StBlank} state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous value commit.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val_in,
  input  logic [3:0]  dp_in,
  input  logic        val_load,
  output logic        busy,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);

  state_e                   state_q;
  logic [1:0]               idx_q;
  logic [TickW-1:0]         tick_cnt_q;
  logic [BlankW-1:0]        blank_cnt_q;
  logic [15:0]              disp_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]    disp_dp_q, pend_dp_q;
  logic                     busy_q, frame_done_q;
  logic [NUM_DIGITS-1:0]    an_q;
  logic [6:0]               seg_q;
  logic                     dp_q;

  logic                     tick_done, blank_done, frame_edge;
  logic [3:0]               nibble;
  logic [6:0]               glyph;
  logic [NUM_DIGITS-1:0]    lz_blank;
  logic [NUM_DIGITS-1:0]    an_d;
  logic [6:0]               seg_d;
  logic                     dp_d;

  assign tick_done  = (state_q == StShow) && (tick_cnt_q == TickLast);
  assign blank_done = (state_q == StBlank) && (blank_cnt_q == BlankLast);
  assign frame_edge = blank_done && (idx_q == 2'd3);

  assign nibble = disp_val_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] nib_zero;
  assign nib_zero = {disp_val_q[15:12] == 4'h0, disp_val_q[11:8] == 4'h0,
                     disp_val_q[7:4] == 4'h0, disp_val_q[3:0] == 4'h0};
  // A digit blanks only if it and every higher digit are zero; digit 0 always shows.
  assign lz_blank = {nib_zero[3], &nib_zero[3:2], &nib_zero[3:1], 1'b0};
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == StShow && digit_en[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = lz_blank[idx_q] ? SEG_OFF : glyph;
      dp_d        = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StBlank;
      idx_q        <= 2'd3;
      tick_cnt_q   <= '0;
      blank_cnt_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      frame_done_q <= frame_edge;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;

      unique case (state_q)
        StShow: begin
          if (tick_done) begin
            tick_cnt_q <= '0;
            state_q    <= StBlank;
          end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
          end
        end
        StBlank: begin
          if (blank_done) begin
            blank_cnt_q <= '0;
            idx_q       <= idx_q + 2'd1;
            state_q     <= StShow;
          end else begin
            blank_cnt_q <= blank_cnt_q + BlankW'(1);
          end
        end
        default: state_q <= StBlank;
      endcase

      // Commit and capture are exclusive: commit needs busy, capture needs !busy.
      if (frame_edge && busy_q) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
        busy_q     <= 1'b0;
      end else if (!busy_q && val_load) begin
        pend_val_q <= val_in;
        pend_dp_q  <= dp_in;
        busy_q     <= 1'b1;
      end
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a timeline-based reference model.
module tb_seg_scan_ctrl;

  localparam int TD    = 4;
  localparam int BC    = 2;
  localparam int DIG   = TD + BC;
  localparam int FRAME = 4 * DIG;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] val_in = '0;
  logic [3:0]  dp_in = '0;
  logic        val_load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic        busy, dp, frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg_scan_ctrl #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .val_in     (val_in),
    .dp_in      (dp_in),
    .val_load   (val_load),
    .busy       (busy),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic bit lead_blank(input logic [15:0] v, input int k);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    return (k != 0) && ((v >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Cycle t (0 = cycle in which reset released) ends with a frame-boundary edge?
  function automatic bit is_boundary(input int t1);
    return (t1 >= BC) && (((t1 - BC) % FRAME) == 0);
  endfunction

  // Reference model: position in the scan timeline is derived arithmetically from m_t.
  int          m_t, mi, mp;
  bit          m_show, m_busy;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pend_dp, m_disp_dp;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1, exp_fd = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0; m_busy = 0; m_pend = '0; m_disp = '0; m_pend_dp = '0; m_disp_dp = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      if (m_t < BC) begin
        m_show = 0; mi = 3;
      end else begin
        mp = (m_t - BC) % FRAME;
        mi = mp / DIG;
        m_show = (mp % DIG) < TD;
      end
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (m_show && digit_en[mi]) begin
        exp_an  = ~(4'b0001 << mi);
        exp_seg = lead_blank(m_disp, mi) ? 7'h7F : glyph_of(m_disp[mi*4 +: 4]);
        exp_dp  = ~m_disp_dp[mi];
      end
      exp_fd = is_boundary(m_t + 1);
      if (is_boundary(m_t + 1) && m_busy) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_busy = 0;
      end else if (!m_busy && val_load) begin
        m_pend = val_in; m_pend_dp = dp_in; m_busy = 1;
      end
      m_t = m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 16'(busy), 16'(m_busy));
      check("an", 16'(an), 16'(exp_an));
      check("seg", 16'(seg), 16'(exp_seg));
      check("dp", 16'(dp), 16'(exp_dp));
      check("frame_done", 16'(frame_done), 16'(exp_fd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) return;
      tick();
    end
    check("fd_timeout", 16'd1, 16'd0);
  endtask

  int last_fd, cyc;

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;

    // Cycle 0: release and load 1234 together.
    tick();
    rst = 1'b1; val_load = 1'b1; val_in = 16'h1234; dp_in = 4'b0000;
    @(negedge clk);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_an", 16'(an), 16'hF);
    check("reset_seg", 16'(seg), 16'h7F);
    tick(); val_load = 1'b0;
    @(negedge clk);
    check("load_busy", 16'(busy), 16'd1);
    tick();
    @(negedge clk);
    check("first_fd", 16'(frame_done), 16'd1);
    check("commit_busy", 16'(busy), 16'd0);
    tick();
    @(negedge clk);
    check("d0_an", 16'(an), 16'b1110);
    check("d0_seg", 16'(seg), 16'h19);
    check("d0_dp", 16'(dp), 16'd1);
    repeat (6) tick();
    @(negedge clk);
    check("d1_an", 16'(an), 16'b1101);
    check("d1_seg", 16'(seg), 16'h30);

    // Second load while busy must be dropped.
    wait_fd();
    tick(); val_load = 1'b1; val_in = 16'hABCD; dp_in = 4'b0001;
    tick(); val_load = 1'b1; val_in = 16'h0000; dp_in = 4'b0000;
    @(negedge clk);
    check("busy_hold", 16'(busy), 16'd1);
    tick(); val_load = 1'b0;
    wait_fd();
    tick();
    @(negedge clk);
    check("abcd_an", 16'(an), 16'b1110);
    check("abcd_seg", 16'(seg), 16'h21);
    check("abcd_dp", 16'(dp), 16'd0);

    // Disabled digits keep their slot.
    tick(); digit_en = 4'b0101;
    last_fd = -1;
    for (cyc = 0; cyc < 60; cyc++) begin
      tick();
      @(negedge clk);
      check("en_mask_an", 16'(an == 4'b1101 || an == 4'b0111), 16'd0);
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) check("fd_period", 16'(cyc - last_fd), 16'(FRAME));
        last_fd = cyc;
      end
    end
    digit_en = 4'hF;

    // Leading zero handling.
    wait_fd();
    tick(); val_load = 1'b1; val_in = 16'h0007; dp_in = 4'b0000;
    tick(); val_load = 1'b0;
    wait_fd();
    tick();
    @(negedge clk);
    check("lz_d0_seg", 16'(seg), 16'h78);
    repeat (6) tick();
    @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check("lz_d1_seg", 16'(seg), 16'h7F);
`else
    check("lz_d1_seg", 16'(seg), 16'h40);
`endif

    // Reset during digit 2 with a pending value.
    wait_fd();
    tick(); val_load = 1'b1; val_in = 16'h5A5A; dp_in = 4'b1111;
    tick(); val_load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === 4'b1011) break;
      tick();
    end
    check("pre_rst_an", 16'(an), 16'b1011);
    check("pre_rst_busy", 16'(busy), 16'd1);
    tick(); rst = 1'b0;
    #1;
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(dp), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_fd", 16'(frame_done), 16'd0);
    tick(); rst = 1'b1;
    wait_fd();
    tick();
    @(negedge clk);
    check("post_rst_seg", 16'(seg), 16'h40);
    check("post_rst_an", 16'(an), 16'b1110);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      val_load = ($urandom_range(0, 5) == 0);
      val_in   = 16'($urandom);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
    end
    rst = 1'b1; val_load = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10000, SHOW-phase length per digit in clk cycles; legal range >=2.
REQ-002 Parameter BLANK_CYCLES, default 16, inter-digit blanking length in clk cycles; legal range >=1.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 val_in  input  16  four hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-006 dp_in  input  4  decimal point per digit, 1 = lit.
REQ-007 val_load  input  1  load strobe; sampled only when busy=0.
REQ-008 busy  output  1  pending value held, not yet committed.
REQ-009 digit_en  input  4  per-digit enable, sampled live each cycle.
REQ-010 an  output  4  anode selects, active-low.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal point, active-low.
REQ-013 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 FSM states: SHOW, BLANK; tick counter runs only in SHOW, blank counter only in BLANK.
REQ-015 SHOW: after TICK_DIV cycles, counter at TICK_DIV-1 -> clear to 0, go to BLANK.
REQ-016 BLANK: after BLANK_CYCLES cycles -> idx = (idx+1) mod 4, clear blank counter, go to SHOW.
REQ-017 Digit period is TICK_DIV+BLANK_CYCLES cycles; frame period is 4x that.
REQ-018 BLANK exit with idx 3 -> 0 is the frame boundary: frame_done=1 for exactly one cycle.
REQ-019 Handshake: val_load=1 while busy=0 -> capture val_in/dp_in into pending regs, busy=1 next cycle.
REQ-020 val_load while busy=1 is ignored; pending regs are not overwritten.
REQ-021 At a frame boundary with busy=1, pending regs go to display regs and busy clears on the same edge.
REQ-022 A load on the commit cycle sees busy=1 and is dropped.
REQ-023 Display regs change only at frame boundaries; no mid-frame tearing.
REQ-024 an, seg, dp are registered and show FSM/idx state with one-cycle latency.
REQ-025 BLANK: an=4'hF, seg=7'h7F, dp=1.
REQ-026 SHOW with digit_en[idx]=1: an bit idx = 0, others 1; seg = decode(nibble idx); dp = ~dp_disp[idx].
REQ-027 SHOW with digit_en[idx]=0: an=4'hF, seg=7'h7F, dp=1; the slot is still consumed so brightness stays constant.
REQ-028 Counter widths are $clog2 of the parameter value, minimum 1; counters never exceed parameter-1.

Reset
REQ-029 While rst=0: state BLANK, idx=3, counters 0, display and pending regs 0, busy=0, frame_done=0, an=4'hF, seg=7'h7F, dp=1.
REQ-030 The first BLANK exit after release wraps idx to 0 and pulses frame_done.
REQ-031 Reset mid-frame or mid-handshake discards pending data; there is no partial commit.

Configuration
REQ-032 Macro SEG_LEADING_ZERO_BLANK_EN defined: in SHOW, digits 3..1 whose nibble and all higher nibbles are 0 drive seg=7'h7F; digit 0 is never blanked; dp is unaffected.
REQ-033 Macro SEG_LEADING_ZERO_BLANK_EN undefined: every enabled digit shows its hex glyph, including 0.

Structure
REQ-034 Package seg_pkg holds NUM_DIGITS=4, SEG_OFF=7'h7F, the 16 hex glyph constants and the FSM state enum.
REQ-035 Sub-module seg_hex_decode: combinational 4-bit nibble to 7-bit active-low glyph (0 -> 7'h40, 8 -> 7'h00).

Verification (bench TICK_DIV=4, BLANK_CYCLES=2)
REQ-036 Release rst, load 16'h1234 at cycle 0 -> busy=1; commit at first boundary (cycle 2); an sequence 1110/1101/1011/0111, seg=glyphs 4,3,2,1, 6 cycles per digit.
REQ-037 Load 16'hABCD, then load 16'h0000 while busy -> second load ignored; the next frame shows ABCD.
REQ-038 digit_en=4'b0101 -> an is never 1101 or 0111, and frame_done period stays 24 cycles.
REQ-039 val=16'h0007 with SEG_LEADING_ZERO_BLANK_EN -> digits 3..1 seg=7'h7F, digit 0 seg=7'h78; without the macro -> digits 3..1 seg=7'h40.
REQ-040 Assert rst mid-SHOW of digit 2 with busy=1 -> outputs immediately match reset values; busy=0; after release, display shows 0000.
REQ-041 Every frame: in each BLANK window an=4'hF for exactly 2 cycles, and frame_done pulses exactly once per 24 cycles.
